// File: rtl/sha_msg_sched.sv
// rtl/sha_msg_sched.sv - SHA-256 message schedule expander, two W words per accepted cycle
module sha_msg_sched (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         w_ready,
  output logic [63:0]  w_out,
  output logic [5:0]   cycle,
  output logic         w_valid,
  output logic         busy,
  output logic         done
);

  localparam int NPAIRS = 32;
  localparam logic [4:0] LAST_P = 5'(NPAIRS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [4:0]  p_q, p_d;
  logic [63:0] w_out_q, w_out_d;
  logic [5:0]  cycle_q, cycle_d;
  logic        w_valid_q, w_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] new_lo, new_hi;
  logic        xfer;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // win_q[k] holds W[2p+k]; both new words read only the current window.
  assign new_lo = sig1(win_q[14]) + win_q[9]  + sig0(win_q[1]) + win_q[0];
  assign new_hi = sig1(win_q[15]) + win_q[10] + sig0(win_q[2]) + win_q[1];
  assign xfer   = w_valid_q && w_ready;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    w_out_d   = w_out_q;
    cycle_d   = cycle_q;
    w_valid_d = w_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < 16; i++) win_d[i] = block_in[511 - 32*i -: 32];
          p_d       = 5'd0;
          w_out_d   = {block_in[479:448], block_in[511:480]};
          cycle_d   = 6'd1;
          w_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          for (int i = 0; i < 14; i++) win_d[i] = win_q[i + 2];
          win_d[14] = new_lo;
          win_d[15] = new_hi;
          p_d       = p_q + 5'd1;
          w_out_d   = {win_q[3], win_q[2]};
          cycle_d   = cycle_q + 6'd1;
          if (p_q == LAST_P) begin
            w_out_d   = '0;
            cycle_d   = 6'd0;
            w_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        w_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      w_out_q   <= '0;
      cycle_q   <= '0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      w_out_q   <= w_out_d;
      cycle_q   <= cycle_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign w_out   = w_out_q;
  assign cycle   = cycle_q;
  assign w_valid = w_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
